// File: rtl/vga_line_reader.sv
// Read side of the two-line ping-pong pixel buffer: VGA timing generation,
// buffer read addressing, read-latency compensation and line ownership
// handshake with the writer.
module vga_line_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 11,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic                  mem_rd_clk,
  input  logic                  mem_rd_rst,
  input  logic [1:0]            line_valid,
  output logic                  line_done,
  output logic                  line_done_bank,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_de,
  output logic [DATA_WIDTH-1:0] vga_data,
  output logic                  frame_start,
  output logic                  underflow,
  input  logic                  clr_underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(H_ACTIVE);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] v_next;
  logic          h_wrap;
  logic          next_active;
  logic          de0, hs0, vs0, fs0, rd0, last_px;
  logic          go, bank;
  logic          de1, hs1, vs1, go1, fs1;
  logic          de2, hs2, vs2, go2, fs2;

  // Counter decode; everything downstream is a fixed 3-stage pipeline of this.
  always_comb begin
    h_wrap      = (h_cnt == H_LAST);
    v_next      = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    next_active = (v_next < V_ACT);
    de0         = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0         = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs0         = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    fs0         = (h_cnt == '0) && (v_cnt == '0);
    rd0         = go && de0;
    last_px     = rd0 && (h_cnt == H_ACT_LAST);
  end

  // Free-running pixel and line counters.
  always_ff @(posedge mem_rd_clk) begin
    if (mem_rd_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) v_cnt <= v_next;
    end
  end

  // Per-line read decision, bank ownership and sticky underflow flag.
  // Line 0 after reset is black because go resets low and no decision preceded it.
  always_ff @(posedge mem_rd_clk) begin
    if (mem_rd_rst) begin
      go        <= 1'b0;
      bank      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (h_wrap) go <= next_active && line_valid[bank];
      if (last_px) bank <= ~bank;
      if (h_wrap && next_active && !line_valid[bank]) underflow <= 1'b1;
      else if (clr_underflow) underflow <= 1'b0;
    end
  end

  // Stage 1: buffer read request plus registered timing and completion pulse.
  always_ff @(posedge mem_rd_clk) begin
    if (mem_rd_rst) begin
      mem_rd_en      <= 1'b0;
      mem_raddr      <= '0;
      line_done      <= 1'b0;
      line_done_bank <= 1'b0;
      {de1, hs1, vs1, go1, fs1} <= '0;
    end else begin
      mem_rd_en      <= rd0;
      mem_raddr      <= rd0 ? ((bank ? BANK1_BASE : '0) + ADDR_WIDTH'(h_cnt)) : '0;
      line_done      <= last_px;
      line_done_bank <= last_px ? bank : 1'b0;
      {de1, hs1, vs1, go1, fs1} <= {de0, hs0, vs0, go, fs0};
    end
  end

  // Stage 2: wait out the buffer's registered read latency.
  always_ff @(posedge mem_rd_clk) begin
    if (mem_rd_rst) {de2, hs2, vs2, go2, fs2} <= '0;
    else            {de2, hs2, vs2, go2, fs2} <= {de1, hs1, vs1, go1, fs1};
  end

  // Stage 3: aligned VGA outputs; undelivered lines show black but keep DE.
  always_ff @(posedge mem_rd_clk) begin
    if (mem_rd_rst) begin
      vga_de      <= 1'b0;
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_de      <= de2;
      vga_hs      <= hs2 ? SYNC_POL : ~SYNC_POL;
      vga_vs      <= vs2 ? SYNC_POL : ~SYNC_POL;
      vga_data    <= (de2 && go2) ? mem_rdata : '0;
      frame_start <= fs2;
    end
  end

endmodule
